// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;

    localparam int unsigned HALF_CNT_DEF  = 521;
    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned BIT_PERIOD    = 1043;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous UART pins; resets to the idle-high level.
module uart_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive framer (8N1), driving the RX baud generator enable.
// Define UART_RX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned HALF_CNT  = HALF_CNT_DEF,
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    input  logic                 rx_br_stb,
    output logic                 rx_br_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int unsigned HC_W = $clog2(HALF_CNT + 1);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

    logic                 rxd_s;
    logic                 rxd_d_q;
    logic                 rxd_fall;

    rx_state_e            state_q,    state_d;
    logic [HC_W-1:0]      half_cnt_q, half_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 br_en_q,    br_en_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q,  par_err_d;
    logic                 perr_q,     perr_d;
`endif

    uart_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    // One extra stage so a high-to-low transition can be seen as a single-cycle edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rxd_d_q <= 1'b1;
        else       rxd_d_q <= rxd_s;
    end

    assign rxd_fall = rxd_d_q & ~rxd_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            br_en_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            br_en_q    <= br_en_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        br_en_d    = br_en_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
        perr_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                br_en_d = 1'b0;
                if (rxd_fall) begin
                    half_cnt_d = '0;
                    state_d    = ST_START;
                end
            end

            // Re-check the start bit at its centre to reject line glitches
            ST_START: begin
                half_cnt_d = half_cnt_q + HC_W'(1);
                if (half_cnt_q == HC_W'(HALF_CNT - 1)) begin
                    if (!rxd_s) begin
                        bit_cnt_d = '0;
                        br_en_d   = 1'b1;
                        state_d   = ST_DATA;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (rx_br_stb) begin
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (rx_br_stb) begin
                    par_err_d = (^shift_q) ^ rxd_s;
                    state_d   = ST_STOP;
                end
            end
`endif

            // Leaving at stop mid-bit lets a following start edge be caught early
            ST_STOP: begin
                if (rx_br_stb) begin
                    br_en_d = 1'b0;
                    data_d  = shift_q;
                    if (rxd_s) begin
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_err_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                br_en_d = 1'b0;
                if (rxd_s) state_d = ST_IDLE;
            end

            default: begin
                br_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_br_en     = br_en_q;
    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: behavioural baud generator, serial driver and output scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned BIT_CLKS = BIT_PERIOD;
    // Start-bit edge to rx_br_en: half bit plus two synchroniser flops and the edge register
    localparam int unsigned EN_LAT   = HALF_CNT_DEF + 3;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       rxd;
    logic       rx_br_stb;
    logic       rx_br_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int unsigned br_cnt;

    uart_rx dut (
        .clk           (clk),
        .rstn          (rstn),
        .rxd           (rxd),
        .rx_br_stb     (rx_br_stb),
        .rx_br_en      (rx_br_en),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Baud generator model: counter held at 0 while disabled, strobe at count 1042
    always @(posedge clk or negedge rstn) begin
        if (!rstn)                     br_cnt <= 0;
        else if (!rx_br_en)            br_cnt <= 0;
        else if (br_cnt == BIT_CLKS-1) br_cnt <= 0;
        else                           br_cnt <= br_cnt + 1;
    end
    assign rx_br_stb = rx_br_en && (br_cnt == BIT_CLKS - 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rstn && (rx_valid || rx_frame_err || rx_parity_err)) begin
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            check("valid_ferr_excl", 32'(rx_valid & rx_frame_err), 32'd0);
            check("en_low_at_pulse", 32'(rx_br_en), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_valid", 32'(rx_valid), 32'(e.valid));
                check("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
                check("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; stop_len sets how long the stop level is held afterwards
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                              input logic par_flip);
        exp_t e;
        int   rise;
        e.data  = d;
        e.valid = stop_v;
        e.ferr  = ~stop_v;
`ifdef UART_RX_PARITY_EN
        e.perr  = par_flip & stop_v;
`else
        e.perr  = 1'b0;
`endif
        sb.push_back(e);
        rise = 0;
        rxd  = 1'b0;
        for (int i = 1; i <= int'(BIT_CLKS); i++) begin
            @(negedge clk);
            if (rise == 0 && rx_br_en) rise = i;
        end
        check("en_rise_clks", 32'(rise), 32'(EN_LAT));
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, BIT_CLKS);
`else
        if (par_flip) hold(1'b1, 0);
`endif
        hold(stop_v, stop_len);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_br_en", 32'(rx_br_en), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_perr", 32'(rx_parity_err), 32'd0);
        rstn = 1'b1;
        hold(1'b1, 20);

        // Basic frame
        send_frame(8'h55, 1'b1, BIT_CLKS + 100, 1'b0);

        // Back-to-back: next start edge 600 clk after the stop mid-sample
        send_frame(8'h00, 1'b1, int'(EN_LAT) + 600, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_CLKS + 100, 1'b0);

        // Short low glitch must not start a frame
        hold(1'b0, 200);
        rxd  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (rx_br_en) seen = 1'b1;
        end
        check("glitch_no_en", 32'(seen), 32'd0);

        // Stop bit low then line held low: one frame error, no retrigger
        send_frame(8'hA5, 1'b0, 600, 1'b0);
        rxd  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4400; i++) begin
            @(negedge clk);
            if (rx_br_en) seen = 1'b1;
        end
        check("break_no_en", 32'(seen), 32'd0);
        check("break_data_held", 32'(rx_data), 32'hA5);
        hold(1'b1, 1000);
        send_frame(8'h3C, 1'b1, BIT_CLKS + 100, 1'b0);

        // Reset in the middle of bit 4 of 0x81; transmitter also abandons the frame
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, BIT_CLKS);
        hold(1'b0, 500);
        check("mid_frame_en", 32'(rx_br_en), 32'd1);
        check("mid_frame_data", 32'(rx_data), 32'h3C);
        rstn = 1'b0;
        rxd  = 1'b1;
        #1;
        check("async_rst_en", 32'(rx_br_en), 32'd0);
        check("async_rst_data", 32'(rx_data), 32'd0);
        check("async_rst_pulses", 32'({rx_valid, rx_frame_err, rx_parity_err}), 32'd0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        hold(1'b1, 1500);
        send_frame(8'h81, 1'b1, BIT_CLKS + 100, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, BIT_CLKS + 100, 1'b0);
        send_frame(8'h07, 1'b1, BIT_CLKS + 100, 1'b1);
`endif

        hold(1'b1, 100);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
